// File: rtl/note_sequencer.sv
// note_sequencer: steps a song ROM of {duration, note} words and drives the tone path's fullnote
// Ports:
//   clk          system clock
//   RESET        asynchronous active-high reset
//   play_toggle  one-cycle pulse, toggles play/pause
//   song_sel     asynchronous song select level
//   rom_addr     ROM word address
//   rom_song     synchronized song_sel, ROM bank select
//   rom_data     {dur[11:8], note[7:0]}, valid one clk after rom_addr/rom_song
//   fullnote     note to the tone path, 0 = silent
//   playing      high while not paused
//   tick         one-cycle pulse per duration tick
//   song_done    one-cycle pulse on the end-of-song marker
module note_sequencer #(
  parameter int TICK_DIV  = 6_250_000,
  parameter int GAP_TICKS = 1,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              play_toggle,
  input  logic              song_sel,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_song,
  input  logic [11:0]       rom_data,
  output logic [7:0]        fullnote,
  output logic              playing,
  output logic              tick,
  output logic              song_done
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int GW = GAP_TICKS > 0 ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [2:0] PAUSED = 3'd0, FETCH = 3'd1, LOAD = 3'd2, PLAY = 3'd3, GAP = 3'd4;
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] G_INIT = GW'(GAP_TICKS);
  logic [2:0] state, resume, adv;
  logic [TW-1:0] tick_cnt;
  logic [3:0] dur_cnt;
  logic [GW-1:0] gap_cnt;
  logic [7:0] note_reg;
  logic s1, s3, chg, busy, last, run_next;
  assign playing = state != PAUSED;
  assign busy = state == PLAY || state == GAP;
  assign tick = busy && tick_cnt == T_LAST;
  assign last = tick && (state == PLAY ? dur_cnt == 4'd1 : gap_cnt == GW'(1));
  assign chg = rom_song ^ s3;
  // after a song change the sequencer runs iff exactly one of "was playing" and "toggle" holds
  assign run_next = playing ^ play_toggle;
  // natural successor of the current state, ignoring pause and song change
  assign adv = state == FETCH ? LOAD :
               state == LOAD ? (rom_data[11:8] != 4'd0 ? PLAY : rom_addr == '0 ? PAUSED : FETCH) :
               last ? ((state == PLAY && GAP_TICKS > 0) ? GAP : FETCH) : state;
  always_ff @(posedge clk or posedge RESET)
    if (RESET) begin
      {s1, rom_song, s3} <= '0;
      state <= PAUSED;
      resume <= FETCH;
      rom_addr <= '0;
      fullnote <= '0;
      song_done <= 1'b0;
      tick_cnt <= '0;
      dur_cnt <= '0;
      gap_cnt <= '0;
      note_reg <= '0;
    end else begin
      {s1, rom_song, s3} <= {song_sel, s1, rom_song};
      song_done <= 1'b0;
      if (chg) begin
        rom_addr <= '0;
        tick_cnt <= '0;
        resume <= FETCH;
        state <= run_next ? FETCH : PAUSED;
        if (!run_next) fullnote <= '0;
      end else if (!playing) begin
        if (play_toggle) state <= resume;
        if (play_toggle && resume == PLAY) fullnote <= note_reg;
      end else begin
        // the cycle carrying the pause pulse still counts as played time
        if (busy) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (tick && state == PLAY) dur_cnt <= dur_cnt - 4'd1;
        if (tick && state == GAP) gap_cnt <= gap_cnt - GW'(1);
        if (last && state == PLAY) begin
          rom_addr <= rom_addr + ADDR_W'(1);
          gap_cnt <= G_INIT;
        end
        if (state == LOAD && !play_toggle && rom_data[11:8] != 4'd0) begin
          note_reg <= rom_data[7:0];
          dur_cnt <= rom_data[11:8];
          tick_cnt <= '0;
        end
        if (state == LOAD && !play_toggle && rom_data[11:8] == 4'd0) begin
          song_done <= 1'b1;
          rom_addr <= '0;
        end
        if (play_toggle) begin
          state <= PAUSED;
          resume <= busy ? adv : FETCH;
          fullnote <= '0;
        end else begin
          state <= adv;
          if (adv == PAUSED) resume <= FETCH;
          if (state == LOAD && adv == PLAY) fullnote <= rom_data[7:0];
          else if (adv == GAP || adv == PAUSED) fullnote <= '0;
        end
      end
    end
endmodule
